// File: rtl/wb_result_sel_pipe_pkg.sv
// Shared types and helpers for the write-back result selector pipeline.
package wb_result_sel_pipe_pkg;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    // Source tag must encode every channel index plus the forced-zero tag (= nch).
    function automatic int unsigned src_w(input int unsigned nch);
        return $clog2(nch + 1);
    endfunction

    function automatic int unsigned zero_src(input int unsigned nch);
        return nch;
    endfunction

endpackage

// File: rtl/wb_result_sel_pipe_prio_sel.sv
// Combinational priority selector: lowest set override channel, else channel 0 when amt != 0, else zero.
module wb_result_sel_pipe_prio_sel
    import wb_result_sel_pipe_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned NCH   = 2,
    parameter int unsigned AMT_W = 5,
    parameter int unsigned SRC_W = src_w(NCH)
) (
    input  logic [NCH*W-1:0] ch_data,
    input  logic [NCH-1:0]   ch_ovr,
    input  logic [AMT_W-1:0] amt,
    output logic [W-1:0]     sel_data_c,
    output logic [SRC_W-1:0] sel_src_c
);

    logic hit;
    logic ovr0_unused;

    // Channel 0 has no override of its own; its flag bit is intentionally ignored.
    assign ovr0_unused = ch_ovr[0];

    always_comb begin
        sel_data_c = '0;
        sel_src_c  = SRC_W'(zero_src(NCH));
        hit        = 1'b0;
        for (int unsigned i = 1; i < NCH; i++) begin
            if (!hit && ch_ovr[i]) begin
                hit        = 1'b1;
                sel_data_c = ch_data[i*W +: W];
                sel_src_c  = SRC_W'(i);
            end
        end
        if (!hit && (amt != '0)) begin
            sel_data_c = ch_data[W-1:0];
            sel_src_c  = '0;
        end
    end

endmodule

// File: rtl/wb_result_sel_pipe.sv
// Write-back result selector with a two-entry skid buffer on a valid/ready output
// and a saturating counter of forced-zero results.
module wb_result_sel_pipe
    import wb_result_sel_pipe_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned NCH   = 2,
    parameter int unsigned AMT_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NCH*W-1:0]          ch_data,
    input  logic [NCH-1:0]            ch_ovr,
    input  logic [AMT_W-1:0]          amt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [W-1:0]              out_data,
    output logic [src_w(NCH)-1:0]     out_src,
    output logic [CNT_W-1:0]          zero_cnt,
    input  logic                      zero_cnt_clr
);

    localparam int unsigned SRC_W = src_w(NCH);
    localparam logic [SRC_W-1:0] ZERO_SRC = SRC_W'(zero_src(NCH));

    buf_state_e       state_q, state_d;
    logic [W-1:0]     main_data_q, main_data_d;
    logic [SRC_W-1:0] main_src_q, main_src_d;
    logic [W-1:0]     skid_data_q, skid_data_d;
    logic [SRC_W-1:0] skid_src_q, skid_src_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;

    logic [W-1:0]     sel_data_c;
    logic [SRC_W-1:0] sel_src_c;
    logic             in_xfer;
    logic             out_xfer;

    wb_result_sel_pipe_prio_sel #(
        .W     (W),
        .NCH   (NCH),
        .AMT_W (AMT_W),
        .SRC_W (SRC_W)
    ) u_prio_sel (
        .ch_data    (ch_data),
        .ch_ovr     (ch_ovr),
        .amt        (amt),
        .sel_data_c (sel_data_c),
        .sel_src_c  (sel_src_c)
    );

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid_q && out_ready;

    // Buffer occupancy and entry movement; main register always holds the oldest entry.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_src_d  = main_src_q;
        skid_data_d = skid_data_q;
        skid_src_d  = skid_src_q;
        case (state_q)
            BUF_EMPTY: begin
                if (in_xfer) begin
                    main_data_d = sel_data_c;
                    main_src_d  = sel_src_c;
                    state_d     = BUF_ONE;
                end
            end
            BUF_ONE: begin
                case ({in_xfer, out_xfer})
                    2'b10: begin
                        skid_data_d = sel_data_c;
                        skid_src_d  = sel_src_c;
                        state_d     = BUF_FULL;
                    end
                    2'b01: state_d = BUF_EMPTY;
                    2'b11: begin
                        main_data_d = sel_data_c;
                        main_src_d  = sel_src_c;
                    end
                    default: ;
                endcase
            end
            BUF_FULL: begin
                if (out_xfer) begin
                    main_data_d = skid_data_q;
                    main_src_d  = skid_src_q;
                    state_d     = BUF_ONE;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
        out_valid_d = (state_d != BUF_EMPTY);
        in_ready_d  = (state_d != BUF_FULL);
    end

    // Clear wins over increment; increment stops at all-ones.
    always_comb begin
        zero_cnt_d = zero_cnt_q;
        if (zero_cnt_clr) begin
            zero_cnt_d = '0;
        end else if (in_xfer && (sel_src_c == ZERO_SRC) && (zero_cnt_q != {CNT_W{1'b1}})) begin
            zero_cnt_d = zero_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BUF_EMPTY;
            main_data_q <= '0;
            main_src_q  <= '0;
            skid_data_q <= '0;
            skid_src_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            zero_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_src_q  <= main_src_d;
            skid_data_q <= skid_data_d;
            skid_src_q  <= skid_src_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            zero_cnt_q  <= zero_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    assign out_src   = main_src_q;
    assign zero_cnt  = zero_cnt_q;

endmodule

// File: tb/tb_wb_result_sel_pipe.sv
// Bench for wb_result_sel_pipe: an NCH=2/CNT_W=2 and an NCH=4/CNT_W=16 instance share
// handshake stimulus and are checked every cycle against a queue-based reference model.
module tb_wb_result_sel_pipe;

    typedef struct {
        logic [31:0] d;
        int          src;
    } ent_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] ch_data;
    logic [3:0]   ch_ovr;
    logic [4:0]   amt;
    logic         clr;

    logic         in_ready2, out_valid2;
    logic [31:0]  out_data2;
    logic [1:0]   out_src2;
    logic [1:0]   zero_cnt2;

    logic         in_ready4, out_valid4;
    logic [31:0]  out_data4;
    logic [2:0]   out_src4;
    logic [15:0]  zero_cnt4;

    int n_cmp = 0;
    int n_err = 0;

    ent_t q2[$];
    ent_t q4[$];
    int   m_cnt2;
    int   m_cnt4;

    wb_result_sel_pipe #(.W(32), .NCH(2), .AMT_W(5), .CNT_W(2)) dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready2),
        .ch_data      (ch_data[63:0]),
        .ch_ovr       (ch_ovr[1:0]),
        .amt          (amt),
        .out_valid    (out_valid2),
        .out_ready    (out_ready),
        .out_data     (out_data2),
        .out_src      (out_src2),
        .zero_cnt     (zero_cnt2),
        .zero_cnt_clr (clr)
    );

    wb_result_sel_pipe #(.W(32), .NCH(4), .AMT_W(5), .CNT_W(16)) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready4),
        .ch_data      (ch_data),
        .ch_ovr       (ch_ovr),
        .amt          (amt),
        .out_valid    (out_valid4),
        .out_ready    (out_ready),
        .out_data     (out_data4),
        .out_src      (out_src4),
        .zero_cnt     (zero_cnt4),
        .zero_cnt_clr (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Selection rule straight from the priority definition.
    function automatic ent_t mdl_sel(input int nch, input logic [127:0] d,
                                     input logic [3:0] ovr, input logic [4:0] a);
        ent_t r;
        for (int i = 1; i < nch; i++) begin
            if (ovr[i]) begin
                r.d   = d[i*32 +: 32];
                r.src = i;
                return r;
            end
        end
        if (a != 5'd0) begin
            r.d   = d[31:0];
            r.src = 0;
        end else begin
            r.d   = 32'd0;
            r.src = nch;
        end
        return r;
    endfunction

    // Reference model: a FIFO of at most two results plus saturating counters.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q2.delete();
            q4.delete();
            m_cnt2 = 0;
            m_cnt4 = 0;
        end else begin
            bit   acc2, acc4;
            ent_t e2, e4;
            e2   = mdl_sel(2, ch_data, ch_ovr, amt);
            e4   = mdl_sel(4, ch_data, ch_ovr, amt);
            acc2 = in_valid && (q2.size() < 2);
            acc4 = in_valid && (q4.size() < 2);
            if (out_ready && q2.size() > 0) void'(q2.pop_front());
            if (out_ready && q4.size() > 0) void'(q4.pop_front());
            if (acc2) q2.push_back(e2);
            if (acc4) q4.push_back(e4);
            if (clr) m_cnt2 = 0;
            else if (acc2 && e2.src == 2 && m_cnt2 < 3) m_cnt2++;
            if (clr) m_cnt4 = 0;
            else if (acc4 && e4.src == 4 && m_cnt4 < 65535) m_cnt4++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready2", 64'(in_ready2), 64'(q2.size() < 2));
            check("out_valid2", 64'(out_valid2), 64'(q2.size() > 0));
            if (q2.size() > 0) begin
                check("out_data2", 64'(out_data2), 64'(q2[0].d));
                check("out_src2", 64'(out_src2), 64'(q2[0].src));
            end
            check("zero_cnt2", 64'(zero_cnt2), 64'(m_cnt2));
            check("in_ready4", 64'(in_ready4), 64'(q4.size() < 2));
            check("out_valid4", 64'(out_valid4), 64'(q4.size() > 0));
            if (q4.size() > 0) begin
                check("out_data4", 64'(out_data4), 64'(q4[0].d));
                check("out_src4", 64'(out_src4), 64'(q4[0].src));
            end
            check("zero_cnt4", 64'(zero_cnt4), 64'(m_cnt4));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ch_data   = '0;
        ch_ovr    = '0;
        amt       = '0;
        clr       = 1'b0;
        #13;
        check("rst_out_valid", 64'(out_valid2), 64'd0);
        check("rst_out_data", 64'(out_data2), 64'd0);
        check("rst_out_src", 64'(out_src2), 64'd0);
        check("rst_zero_cnt", 64'(zero_cnt2), 64'd0);
        #10 rst_n = 1'b1;
        cyc();
        check("rst_in_ready", 64'(in_ready2), 64'd1);

        // Override channel 1 wins.
        in_valid = 1'b1;
        ch_ovr   = 4'b0010;
        amt      = 5'd0;
        ch_data  = {64'd0, 32'hAAAA0000, 32'h00001234};
        cyc();
        in_valid = 1'b0;
        #1;
        check("ovr1_data", 64'(out_data2), 64'h0000_0000_AAAA_0000);
        check("ovr1_src", 64'(out_src2), 64'd1);

        // Default channel with non-zero amount, then forced zero.
        cyc();
        in_valid = 1'b1;
        ch_ovr   = 4'b0000;
        amt      = 5'd3;
        cyc();
        amt = 5'd0;
        #1;
        check("amt_data", 64'(out_data2), 64'h1234);
        check("amt_src", 64'(out_src2), 64'd0);
        cyc();
        in_valid = 1'b0;
        #1;
        check("zero_data", 64'(out_data2), 64'd0);
        check("zero_src2", 64'(out_src2), 64'd2);
        check("zero_src4", 64'(out_src4), 64'd4);
        check("zero_cnt_one", 64'(zero_cnt2), 64'd1);

        // Four-channel priority, bit 0 ignored.
        cyc();
        in_valid = 1'b1;
        ch_data  = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
        ch_ovr   = 4'b1100;
        cyc();
        ch_ovr = 4'b1001;
        #1;
        check("nch4_src2", 64'(out_src4), 64'd2);
        check("nch4_data2", 64'(out_data4), 64'h22222222);
        cyc();
        in_valid = 1'b0;
        #1;
        check("nch4_src3", 64'(out_src4), 64'd3);
        check("nch4_data3", 64'(out_data4), 64'h33333333);

        // Back-pressure: A, B fill the buffer, C is held off until space frees.
        cyc();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ch_ovr    = 4'b0010;
        ch_data   = {96'd0, 32'hA};
        ch_data[63:32] = 32'hA;
        cyc();
        ch_data[63:32] = 32'hB;
        cyc();
        ch_data[63:32] = 32'hC;
        #1;
        check("bp_in_ready_low", 64'(in_ready2), 64'd0);
        check("bp_hold_a", 64'(out_data2), 64'hA);
        cyc();
        out_ready = 1'b1;
        #1;
        check("bp_still_a", 64'(out_data2), 64'hA);
        cyc();
        #1;
        check("bp_b", 64'(out_data2), 64'hB);
        check("bp_b_valid", 64'(out_valid2), 64'd1);
        cyc();
        in_valid = 1'b0;
        #1;
        check("bp_c", 64'(out_data2), 64'hC);
        check("bp_c_valid", 64'(out_valid2), 64'd1);

        // Saturating counter and clear-over-increment priority.
        cyc();
        clr = 1'b1;
        cyc();
        clr      = 1'b0;
        in_valid = 1'b1;
        ch_ovr   = 4'b0000;
        amt      = 5'd0;
        repeat (4) cyc();
        in_valid = 1'b0;
        #1;
        check("cnt_sat2", 64'(zero_cnt2), 64'd3);
        check("cnt_four4", 64'(zero_cnt4), 64'd4);
        cyc();
        clr      = 1'b1;
        in_valid = 1'b1;
        cyc();
        clr      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("cnt_clr2", 64'(zero_cnt2), 64'd0);
        check("cnt_clr4", 64'(zero_cnt4), 64'd0);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            ch_data   = {$urandom, $urandom, $urandom, $urandom};
            ch_ovr    = 4'($urandom_range(15));
            if ($urandom_range(1) == 0) ch_ovr = 4'd0;
            amt       = ($urandom_range(2) == 0) ? 5'd0 : 5'($urandom_range(31));
            clr       = ($urandom_range(63) == 0);
        end

        // Asynchronous reset while the buffer is full.
        cyc();
        clr       = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ch_ovr    = 4'b0010;
        ch_data   = {$urandom, $urandom, $urandom, 32'h5555AAAA};
        ch_data[63:32] = 32'hDEADBEEF;
        repeat (3) cyc();
        check("full_in_ready", 64'(in_ready2), 64'd0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("arst_out_valid2", 64'(out_valid2), 64'd0);
        check("arst_out_data2", 64'(out_data2), 64'd0);
        check("arst_out_valid4", 64'(out_valid4), 64'd0);
        check("arst_out_data4", 64'(out_data4), 64'd0);
        #10 rst_n = 1'b1;
        out_ready = 1'b1;
        cyc();
        #1;
        check("post_rst_in_ready", 64'(in_ready2), 64'd1);
        check("post_rst_out_valid", 64'(out_valid2), 64'd0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_result_sel_pipe.md
# wb_result_sel_pipe

Registered, parametrised write-back result selector for the lab datapath. Picks one of NCH W-bit candidate results by priority: override channels first, then the default channel when the shift/condition amount is non-zero, otherwise forces zero. The result is delivered through a valid/ready handshake backed by a two-entry skid buffer, so the ALU stage can be stalled by the register-file write port without losing results. It sits between the ALU/shifter outputs and the register-file write port.

## Interface
- W, 32, data width of every channel and of the output
- NCH, 2, number of candidate channels (≥2); channel 0 is the default channel, channels 1..NCH-1 are override channels
- AMT_W, 5, width of the amount/condition field
- CNT_W, 16, width of the zero-result statistics counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  candidate set valid this cycle
- in_ready  out  1  block can accept a candidate set
- ch_data  in  NCH*W  packed candidates; channel i at bits [i*W +: W]
- ch_ovr  in  NCH  override flags; bit 0 ignored
- amt  in  AMT_W  amount/condition; non-zero enables channel 0
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  W  selected result
- out_src  out  $clog2(NCH+1)  source tag: channel index, or NCH for forced zero
- zero_cnt  out  CNT_W  saturating count of forced-zero results accepted
- zero_cnt_clr  in  1  synchronous clear of zero_cnt

## Operation
- Selection (combinational, on input side): if any ch_ovr[i] for i≥1 is set, pick the lowest such i; else if amt≠0 pick channel 0; else result is all-zero with src = NCH.
- NCH=2 reproduces the current behaviour: ch_ovr[1] high → channel 1; else amt≠0 → channel 0; else 0.
- Input handshake: transfer when in_valid && in_ready. Output handshake: transfer when out_valid && out_ready.
- Buffer states: EMPTY (0 entries), ONE (main register valid), FULL (main + skid valid).
  - EMPTY: in xfer → ONE.
  - ONE: in xfer without out xfer → FULL (new entry into skid); out xfer without in xfer → EMPTY; both → ONE with main replaced by new entry.
  - FULL: out xfer → ONE, skid moves to main; in_ready is low, no input accepted.
- Ordering strictly FIFO; no entry dropped or duplicated.
- zero_cnt increments by 1 on an input transfer whose src = NCH; saturates at all-ones; zero_cnt_clr has priority over increment in the same cycle.

## Timing
- Reset (rst_n low, asynchronous): state EMPTY, out_valid=0, out_data=0, out_src=0, zero_cnt=0, in_ready=1 after deassertion.
- Reset mid-operation discards all buffered entries immediately.
- in_ready is a registered output: in_ready = (state≠FULL); never depends combinationally on out_ready.
- Latency: input accepted in cycle n appears on out_data/out_valid in cycle n+1 when buffer was EMPTY or ONE-draining.
- Throughput: one result per cycle with out_ready held high.
- out_data/out_src stable while out_valid && !out_ready.
- Simultaneous in and out transfer in ONE: occupancy unchanged.
- ch_data/ch_ovr/amt sampled only on input transfer; values otherwise ignored.

## Structure
- Shared package: source-tag width function, ZERO_SRC constant (= NCH), buffer state enum (EMPTY/ONE/FULL).
- One sub-module natural: wb_prio_sel (purely combinational priority selector producing data and tag); the top holds skid buffer, state machine, and counter.

## Test plan
- NCH=2, out_ready=1: ch_ovr=2'b10, ch_data={32'hAAAA0000, 32'h00001234}, amt=0 → next cycle out_data=32'hAAAA0000, out_src=1.
- NCH=2: ch_ovr=0, amt=5'd3, ch0=32'h00001234 → out_data=32'h00001234, src=0; then amt=0 → out_data=0, src=2, zero_cnt=1.
- NCH=4: ch_ovr=4'b1100 → out_src=2; ch_ovr=4'b1001 (bit 0 ignored) → out_src=3.
- Back-pressure: out_ready=0, push A, B → in_ready drops after B, C held off; raise out_ready → A, B, C emitted in order, one per cycle, no gaps.
- Counter: CNT_W=2, four zero results → zero_cnt=3 (saturated); zero_cnt_clr with simultaneous zero input → zero_cnt=0.
- Reset mid-FULL: assert rst_n=0 asynchronously → out_valid=0, out_data=0 immediately; after release in_ready=1, no stale output.
